// File: rtl/md5_match_dispatch.sv
// md5_match_dispatch: round-robin candidate issue to an md5core array,
// in-order return matching against a latched 128-bit target hash.
module md5_match_dispatch #(
  parameter int NUM_CORES     = 4,
  parameter int MSG_W         = 152,
  parameter int POS_W         = 16,
  parameter bit STOP_ON_MATCH = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [POS_W-1:0]           num_msgs,
  input  logic [127:0]               target_hash,
  input  logic [MSG_W-1:0]           msg_in,
  input  logic                       msg_in_valid,
  output logic                       msg_in_ready,
  output logic [MSG_W-1:0]           core_msg,
  output logic [NUM_CORES-1:0]       core_valid,
  input  logic [NUM_CORES*128-1:0]   core_hash,
  input  logic [NUM_CORES*MSG_W-1:0] core_msg_ret,
  input  logic [NUM_CORES-1:0]       core_ret_valid,
  output logic                       busy,
  output logic                       done,
  output logic                       match,
  output logic [POS_W-1:0]           match_pos,
  output logic [MSG_W-1:0]           match_msg,
  output logic [POS_W-1:0]           match_count,
  output logic                       err
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state;
  logic [POS_W-1:0] job_len;
  logic [POS_W-1:0] issued;
  logic [POS_W-1:0] returned;
  logic [127:0]     target;
  logic [PTR_W-1:0] rr_ptr;

  logic             stopped;
  logic             accept;
  logic             ret_any;
  logic             ret_multi;
  logic             ret_live;
  logic             outstanding;
  logic             ret_take;
  logic             hit;
  logic [127:0]     sel_hash;
  logic [MSG_W-1:0] sel_msg;
  logic [POS_W-1:0] returned_nxt;
  logic [POS_W-1:0] count_nxt;
  logic [PTR_W-1:0] rr_nxt;

  assign stopped      = STOP_ON_MATCH && match;
  assign msg_in_ready = (state == S_RUN) && (issued < job_len)
                        && !stopped;
  assign accept       = msg_in_valid && msg_in_ready;
  assign busy         = (state == S_RUN) || (state == S_DRAIN);

  // Lowest-index return wins when several cores report at once.
  always_comb begin
    ret_any  = 1'b0;
    sel_hash = '0;
    sel_msg  = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (core_ret_valid[i]) begin
        ret_any  = 1'b1;
        sel_hash = core_hash[i*128 +: 128];
        sel_msg  = core_msg_ret[i*MSG_W +: MSG_W];
      end
    end
  end

  assign ret_multi = |(core_ret_valid
                       & (core_ret_valid - NUM_CORES'(1)));
  assign ret_live     = (state != S_IDLE);
  assign outstanding  = (returned != issued);
  assign ret_take     = ret_live && ret_any && outstanding;
  assign hit          = ret_take && (sel_hash == target);
  assign returned_nxt = returned + POS_W'(ret_take);
  assign count_nxt    = (match_count == '1) ? match_count
                        : match_count + POS_W'(1);
  assign rr_nxt       = (rr_ptr == PTR_W'(NUM_CORES - 1)) ? '0
                        : rr_ptr + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      job_len     <= '0;
      issued      <= '0;
      returned    <= '0;
      target      <= '0;
      rr_ptr      <= '0;
      core_msg    <= '0;
      core_valid  <= '0;
      done        <= 1'b0;
      match       <= 1'b0;
      match_pos   <= '0;
      match_msg   <= '0;
      match_count <= '0;
      err         <= 1'b0;
    end else begin
      done       <= (state == S_DONE);
      core_valid <= '0;

      if (accept) begin
        core_msg   <= msg_in;
        core_valid <= NUM_CORES'(1) << rr_ptr;
        rr_ptr     <= rr_nxt;
        issued     <= issued + POS_W'(1);
      end

      if (ret_live && ret_any && (ret_multi || !outstanding)) begin
        err <= 1'b1;
      end

      // Returns arrive in issue order, so the index is the count.
      if (ret_take) begin
        returned <= returned_nxt;
        if (hit) begin
          match_count <= count_nxt;
          if (!match) begin
            match     <= 1'b1;
            match_pos <= returned;
            match_msg <= sel_msg;
          end
        end
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            job_len     <= num_msgs;
            target      <= target_hash;
            issued      <= '0;
            returned    <= '0;
            match       <= 1'b0;
            match_pos   <= '0;
            match_msg   <= '0;
            match_count <= '0;
            err         <= 1'b0;
            state <= (num_msgs == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if ((issued == job_len) || stopped) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (returned_nxt == issued) begin
            state <= S_DONE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md5_match_dispatch.sv
// tb_md5_match_dispatch: two dispatchers (stop / no-stop) fed by
// fixed-latency core models, table-driven job vectors.
module tb_md5_match_dispatch;

  localparam int NC  = 4;
  localparam int MW  = 152;
  localparam int PW  = 16;
  localparam logic [127:0] KEY = 128'hDEAD_BEEF_0BAD_F00D_CAFE_BABE_1234_5678;
  localparam logic [127:0] HC  = 128'h6745_2301_EFCD_AB89_98BA_DCFE_1032_5476;

  typedef struct {
    int num;
    int m1;
    int m2;
    int inj_at;
    int restart_at;
    int iss0;
    int iss1;
    int mt;
    int pos;
    int cnt0;
    int cnt1;
    int er;
    int dlat;
  } vec_t;

  logic clk;
  logic rst_n;
  logic start;
  logic [PW-1:0] num_msgs;
  logic [127:0] tgt;
  logic mvalid;
  logic [NC-1:0] inj;

  logic [MW-1:0]    mi[2];
  logic             rdy[2];
  logic [MW-1:0]    cmsg[2];
  logic [NC-1:0]    cv[2];
  logic [NC*128-1:0] chash[2];
  logic [NC*MW-1:0] cret[2];
  logic [NC-1:0]    crv[2];
  logic             bsy[2];
  logic             dn[2];
  logic             mt[2];
  logic [PW-1:0]    mpos[2];
  logic [MW-1:0]    mmsg[2];
  logic [PW-1:0]    mcnt[2];
  logic             er[2];

  logic [NC-1:0] pv[2][3];
  logic [MW-1:0] pm[2][3];
  int fk[2];
  int rr[2];
  int jm1;
  int jm2;
  int checks;
  int failures;
  vec_t tbl[10];

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    md5_match_dispatch #(
      .NUM_CORES(NC),
      .MSG_W(MW),
      .POS_W(PW),
      .STOP_ON_MATCH(g == 0)
    ) dut (
      .clk(clk),
      .reset(rst_n),
      .start(start),
      .num_msgs(num_msgs),
      .target_hash(tgt),
      .msg_in(mi[g]),
      .msg_in_valid(mvalid),
      .msg_in_ready(rdy[g]),
      .core_msg(cmsg[g]),
      .core_valid(cv[g]),
      .core_hash(chash[g]),
      .core_msg_ret(cret[g]),
      .core_ret_valid(crv[g]),
      .busy(bsy[g]),
      .done(dn[g]),
      .match(mt[g]),
      .match_pos(mpos[g]),
      .match_msg(mmsg[g]),
      .match_count(mcnt[g]),
      .err(er[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] hsh(input logic [MW-1:0] m);
    logic [127:0] lo;
    lo = m[127:0];
    return {lo[63:0], lo[127:64]} ^ HC;
  endfunction

  function automatic logic [MW-1:0] mk_msg(input int k);
    logic [127:0] lo;
    logic [15:0] kk;
    kk = k[15:0];
    lo = (k == jm1 || k == jm2) ? KEY : {96'h0, 16'h5A5A, kk};
    return {8'hA0, kk, lo};
  endfunction

  // Core array model: three-cycle fixed latency, in-order.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      pv[g][0] <= cv[g];
      pv[g][1] <= pv[g][0];
      pv[g][2] <= pv[g][1];
      pm[g][0] <= cmsg[g];
      pm[g][1] <= pm[g][0];
      pm[g][2] <= pm[g][1];
      if (start && !bsy[g]) begin
        fk[g] <= 0;
        mi[g] <= mk_msg(0);
      end else if (mvalid && rdy[g]) begin
        fk[g] <= fk[g] + 1;
        mi[g] <= mk_msg(fk[g] + 1);
      end
    end
  end

  always_comb begin
    for (int g = 0; g < 2; g++) begin
      crv[g]   = pv[g][2] | inj;
      chash[g] = {NC{hsh(pm[g][2])}};
      cret[g]  = {NC{pm[g][2]}};
    end
  end

  task automatic chk(input string nm, input logic [159:0] act,
                     input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic do_job(input vec_t v, input int idx);
    int dcnt[2];
    int dfirst[2];
    int bcnt[2];
    int acc[2];
    int post;
    string nm;
    jm1 = v.m1;
    jm2 = v.m2;
    @(negedge clk);
    num_msgs = 16'(v.num);
    tgt      = hsh({24'h0, KEY});
    start    = 1'b1;
    mvalid   = 1'b1;
    inj      = '0;
    post     = -1;
    for (int g = 0; g < 2; g++) begin
      dcnt[g] = 0; dfirst[g] = -1; bcnt[g] = 0; acc[g] = 0;
    end
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      start = (n == v.restart_at);
      if (start) num_msgs = 16'd2;
      inj = (n == v.inj_at) ? 4'b0011 : 4'b0000;
      for (int g = 0; g < 2; g++) begin
        if (dn[g]) begin
          dcnt[g]++;
          if (dfirst[g] < 0) dfirst[g] = n;
        end
        if (bsy[g]) bcnt[g]++;
        if (cv[g] != '0) begin
          acc[g]++;
          nm = $sformatf("j%0d/u%0d/rr", idx, g);
          chk(nm, cv[g], 4'b0001 << rr[g]);
          rr[g] = (rr[g] + 1) % NC;
        end
      end
      if (post < 0 && dcnt[0] > 0 && dcnt[1] > 0) post = n + 3;
      if (n == post) break;
    end
    mvalid = 1'b0;
    start  = 1'b0;
    for (int g = 0; g < 2; g++) begin
      nm = $sformatf("j%0d/u%0d/", idx, g);
      chk({nm, "done_pulses"}, dcnt[g], 1);
      chk({nm, "issued"}, acc[g], (g == 0) ? v.iss0 : v.iss1);
      chk({nm, "match"}, mt[g], v.mt[0]);
      chk({nm, "match_pos"}, mpos[g], v.pos);
      chk({nm, "match_msg"}, mmsg[g], v.mt != 0 ? mk_msg(v.pos) : '0);
      chk({nm, "match_count"}, mcnt[g], (g == 0) ? v.cnt0 : v.cnt1);
      chk({nm, "err"}, er[g], v.er[0]);
      chk({nm, "busy_after"}, bsy[g], 0);
      chk({nm, "busy_seen"}, bcnt[g] > 0, v.num > 0);
      if (v.dlat > 0) chk({nm, "done_lat"}, dfirst[g], v.dlat);
    end
  endtask

  task automatic reset_mid_drain();
    int dseen;
    string nm;
    jm1 = 3;
    jm2 = -1;
    dseen = 0;
    @(negedge clk);
    num_msgs = 16'd4;
    tgt      = hsh({24'h0, KEY});
    start    = 1'b1;
    mvalid   = 1'b1;
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 6) rst_n = 1'b0;
      for (int g = 0; g < 2; g++) begin
        if (n == 6) begin
          nm = $sformatf("rst/u%0d/drain_busy", g);
          chk(nm, bsy[g], 1);
        end
        if (n == 7) begin
          nm = $sformatf("rst/u%0d/", g);
          chk({nm, "busy"}, bsy[g], 0);
          chk({nm, "ready"}, rdy[g], 0);
          chk({nm, "core_valid"}, cv[g], 0);
          chk({nm, "match_count"}, mcnt[g], 0);
        end
        if (dn[g]) dseen++;
      end
      if (n == 7) rst_n = 1'b1;
    end
    mvalid = 1'b0;
    for (int g = 0; g < 2; g++) begin
      nm = $sformatf("rst/u%0d/", g);
      chk({nm, "late_err"}, er[g], 0);
      chk({nm, "late_match"}, mt[g], 0);
      chk({nm, "late_busy"}, bsy[g], 0);
      rr[g] = 0;
    end
    chk("rst/done_seen", dseen, 0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    num_msgs = '0;
    tgt      = '0;
    mvalid   = 1'b0;
    inj      = '0;
    jm1      = -1;
    jm2      = -1;
    rr[0]    = 0;
    rr[1]    = 0;

    tbl[0] = '{8,   -1, -1, 0, 0, 8, 8,   0, 0, 0, 0, 0, 0};
    tbl[1] = '{8,    5, -1, 0, 0, 8, 8,   1, 5, 1, 1, 0, 0};
    tbl[2] = '{100,  3, -1, 0, 0, 8, 100, 1, 3, 1, 1, 0, 0};
    tbl[3] = '{100,  2,  7, 0, 0, 7, 100, 1, 2, 1, 2, 0, 0};
    tbl[4] = '{0,   -1, -1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 2};
    tbl[5] = '{1,    0, -1, 0, 0, 1, 1,   1, 0, 1, 1, 0, 0};
    tbl[6] = '{3,    1,  2, 0, 0, 3, 3,   1, 1, 2, 2, 0, 0};
    tbl[7] = '{4,   -1, -1, 1, 0, 4, 4,   0, 0, 0, 0, 1, 0};
    tbl[8] = '{6,   -1, -1, 0, 3, 6, 6,   0, 0, 0, 0, 0, 0};
    tbl[9] = '{5,    4, -1, 0, 0, 5, 5,   1, 4, 1, 1, 0, 0};

    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("reset/busy", bsy[g], 0);
      chk("reset/done", dn[g], 0);
      chk("reset/match", mt[g], 0);
      chk("reset/match_pos", mpos[g], 0);
      chk("reset/match_msg", mmsg[g], 0);
      chk("reset/match_count", mcnt[g], 0);
      chk("reset/err", er[g], 0);
      chk("reset/core_valid", cv[g], 0);
      chk("reset/core_msg", cmsg[g], 0);
      chk("reset/ready", rdy[g], 0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      if (i == 5) reset_mid_drain();
      do_job(tbl[i], i);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
